// File: rtl/vram_slot_arbiter_if.sv
// VRAM arbiter bus bundle: timing, video fetch, CPU strobe and RAM pins.
// slave = arbiter side, master = requesters/RAM side.
interface vram_slot_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          hb;
  logic          vb;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_valid;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_busy;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          starve_flag;

  modport slave (
    input  hb, vb, vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output vid_gnt, vid_valid, vid_rdata,
    output cpu_busy, cpu_ack, cpu_rdata,
    output mem_addr, mem_we, mem_wdata,
    output starve_flag
  );

  modport master (
    output hb, vb, vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  vid_gnt, vid_valid, vid_rdata,
    input  cpu_busy, cpu_ack, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata,
    input  starve_flag
  );
endinterface

// File: rtl/vram_slot_arbiter.sv
// Single-port VRAM arbiter: CPU owns blanking, video owns active display
// except one CPU slot per CPU_SLOT_DIV cycles. Ports: vclk, reset, bus
// (slave). Optional starvation guard enabled by macro STARVE_GUARD_EN.
module vram_slot_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 8,
  parameter int CPU_SLOT_DIV = 4,
  parameter int STARVE_MAX   = 15
) (
  input logic                vclk,
  input logic                reset,
  vram_slot_arbiter_if.slave bus
);
  localparam int SW = $clog2(CPU_SLOT_DIV);
  localparam logic [SW-1:0] LAST = SW'(CPU_SLOT_DIV - 1);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_max
    $error("STARVE_MAX out of range");
  end

  logic [SW-1:0] slot_cnt;
  logic          pend;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          busy;
  logic          s1_cpu;
  logic          s1_vid;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic          ack_q;
  logic          val_q;
  logic [DW-1:0] crd_q;
  logic [DW-1:0] vrd_q;
  logic          blank;
  logic          cpu_slot;
  logic          force_c;
  logic          take_cpu;
  logic          take_vid;

  assign blank    = bus.hb | bus.vb;
  assign cpu_slot = blank | (slot_cnt == LAST);

  always_comb begin
    take_cpu = 1'b0;
    take_vid = 1'b0;
    if (force_c && pend) begin
      take_cpu = 1'b1;
    end else if (cpu_slot) begin
      if (pend) take_cpu = 1'b1;
      else      take_vid = bus.vid_req;
    end else begin
      if (bus.vid_req) take_vid = 1'b1;
      else             take_cpu = pend;
    end
  end

`ifdef STARVE_GUARD_EN
  logic [7:0] starve_cnt;
  logic       flag_q;

  assign force_c         = (starve_cnt >= 8'(STARVE_MAX));
  assign bus.starve_flag = flag_q;

  always_ff @(posedge vclk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      flag_q     <= 1'b0;
    end else begin
      if (take_cpu)
        starve_cnt <= '0;
      else if (pend && starve_cnt != 8'hff)
        starve_cnt <= starve_cnt + 8'd1;
      if (force_c && pend)
        flag_q <= 1'b1;
    end
  end
`else
  assign force_c         = 1'b0;
  assign bus.starve_flag = 1'b0;
`endif

  always_ff @(posedge vclk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      pend     <= 1'b0;
      p_we     <= 1'b0;
      p_addr   <= '0;
      p_wdata  <= '0;
      busy     <= 1'b0;
      s1_cpu   <= 1'b0;
      s1_vid   <= 1'b0;
      m_addr   <= '0;
      m_we     <= 1'b0;
      m_wdata  <= '0;
      ack_q    <= 1'b0;
      val_q    <= 1'b0;
      crd_q    <= '0;
      vrd_q    <= '0;
    end else begin
      slot_cnt <= blank ? '0 : slot_cnt + SW'(1);

      // capture needs busy low, issue needs pend high: never both
      if (bus.cpu_req && !busy) begin
        pend    <= 1'b1;
        p_we    <= bus.cpu_we;
        p_addr  <= bus.cpu_addr;
        p_wdata <= bus.cpu_wdata;
        busy    <= 1'b1;
      end else if (take_cpu) begin
        pend <= 1'b0;
      end
      if (ack_q) busy <= 1'b0;

      s1_cpu <= take_cpu;
      s1_vid <= take_vid;
      if (take_cpu) begin
        m_addr  <= p_addr;
        m_we    <= p_we;
        m_wdata <= p_wdata;
      end else begin
        if (take_vid) m_addr <= bus.vid_addr;
        m_we <= 1'b0;
      end

      ack_q <= s1_cpu;
      val_q <= s1_vid;
      if (s1_vid)          vrd_q <= bus.mem_rdata;
      if (s1_cpu && !m_we) crd_q <= bus.mem_rdata;
    end
  end

  assign bus.vid_gnt   = take_vid & ~reset;
  assign bus.vid_valid = val_q;
  assign bus.vid_rdata = vrd_q;
  assign bus.cpu_busy  = busy;
  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_rdata = crd_q;
  assign bus.mem_addr  = m_addr;
  assign bus.mem_we    = m_we;
  assign bus.mem_wdata = m_wdata;
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: scoreboard of expected CPU/video read data
// plus per-cycle grant/pipeline checks; second instance for the guard.
module tb_vram_slot_arbiter;
  logic vclk = 1'b0;
  logic reset;
  always #5 vclk = ~vclk;

  vram_slot_arbiter_if #(.AW(14), .DW(8)) b();
  vram_slot_arbiter_if #(.AW(14), .DW(8)) b16();

  vram_slot_arbiter #(
    .AW(14), .DW(8), .CPU_SLOT_DIV(4), .STARVE_MAX(15)
  ) u_dut (.vclk(vclk), .reset(reset), .bus(b));

  vram_slot_arbiter #(
    .AW(14), .DW(8), .CPU_SLOT_DIV(16), .STARVE_MAX(2)
  ) u_dut16 (.vclk(vclk), .reset(reset), .bus(b16));

`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int K = GUARD ? 3 : 15;

  int vec = 0;
  int errs = 0;
  logic [7:0] cpu_q[$];
  logic [7:0] vid_q[$];
  logic [7:0] exp_crd;
  logic [7:0] mon_e;
  logic [7:0] ram [0:16383];
  bit ram_init;

  function automatic logic [7:0] ramf(input logic [13:0] a);
    return 8'(a * 7 + 3);
  endfunction

  always @(posedge vclk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16384; i++) ram[i] <= ramf(14'(i));
      ram_init <= 1'b1;
    end else if (b.mem_we) begin
      ram[b.mem_addr] <= b.mem_wdata;
    end
  end

  assign b.mem_rdata   = ram[b.mem_addr];
  assign b16.mem_rdata = ramf(b16.mem_addr);

  always @(negedge vclk) begin
    if (!reset) begin
      if (b.cpu_ack) begin
        vec++;
        if (cpu_q.size() == 0) begin
          errs++;
          $display("FAIL sb_cpu: unexpected ack rdata=%h", b.cpu_rdata);
        end else begin
          mon_e = cpu_q.pop_front();
          if (b.cpu_rdata !== mon_e) begin
            errs++;
            $display("FAIL sb_cpu: got %h want %h", b.cpu_rdata, mon_e);
          end
        end
      end
      if (b.vid_valid) begin
        vec++;
        if (vid_q.size() == 0) begin
          errs++;
          $display("FAIL sb_vid: unexpected valid rdata=%h", b.vid_rdata);
        end else begin
          mon_e = vid_q.pop_front();
          if (b.vid_rdata !== mon_e) begin
            errs++;
            $display("FAIL sb_vid: got %h want %h", b.vid_rdata, mon_e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge vclk);
    #1;
  endtask

  function automatic logic [50:0] outs_b();
    return {b.vid_gnt, b.vid_valid, b.vid_rdata, b.cpu_busy, b.cpu_ack,
            b.cpu_rdata, b.mem_addr, b.mem_we, b.mem_wdata, b.starve_flag};
  endfunction

  function automatic logic [50:0] outs_b16();
    return {b16.vid_gnt, b16.vid_valid, b16.vid_rdata, b16.cpu_busy,
            b16.cpu_ack, b16.cpu_rdata, b16.mem_addr, b16.mem_we,
            b16.mem_wdata, b16.starve_flag};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    b.hb = 1'b1; b.vb = 1'b0; b.vid_req = 1'b0; b.vid_addr = '0;
    b.cpu_req = 1'b0; b.cpu_we = 1'b0; b.cpu_addr = '0; b.cpu_wdata = '0;
    b16.hb = 1'b1; b16.vb = 1'b0; b16.vid_req = 1'b0; b16.vid_addr = '0;
    b16.cpu_req = 1'b0; b16.cpu_we = 1'b0;
    b16.cpu_addr = '0; b16.cpu_wdata = '0;
    exp_crd = 8'h00;
    tick; tick;
    vec++;
    if (outs_b() !== '0) begin
      errs++; $display("FAIL reset_outs: got %h want 0", outs_b());
    end
    vec++;
    if (outs_b16() !== '0) begin
      errs++; $display("FAIL reset_outs16: got %h want 0", outs_b16());
    end
    reset = 1'b0;
  endtask

  task automatic test_blank_rw();
    b.hb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      b.cpu_req = 1'b1; b.cpu_we = (k == 0);
      b.cpu_addr = 14'h0123; b.cpu_wdata = 8'hA5;
      cpu_q.push_back(k == 0 ? exp_crd : 8'hA5);
      if (k == 1) exp_crd = 8'hA5;
      tick; b.cpu_req = 1'b0; #1;
      vec++;
      if (b.cpu_busy !== 1'b1) begin
        errs++; $display("FAIL blank_busy: got %b want 1", b.cpu_busy);
      end
      tick; #1;
      vec++;
      if (b.mem_addr !== 14'h0123 || b.mem_we !== (k == 0)) begin
        errs++;
        $display("FAIL blank_mem: addr=%h we=%b want 0123/%b",
                 b.mem_addr, b.mem_we, k == 0);
      end
      tick; #1;
      vec++;
      if (b.cpu_ack !== 1'b1 || b.cpu_busy !== 1'b1) begin
        errs++;
        $display("FAIL blank_ack: ack=%b busy=%b want 1/1",
                 b.cpu_ack, b.cpu_busy);
      end
      tick; #1;
      vec++;
      if (b.cpu_ack !== 1'b0 || b.cpu_busy !== 1'b0) begin
        errs++;
        $display("FAIL blank_release: ack=%b busy=%b want 0/0",
                 b.cpu_ack, b.cpu_busy);
      end
    end
  endtask

  task automatic test_active_slot();
    logic gh [0:11];
    int wes;
    wes = 0;
    for (int j = 0; j < 12; j++) begin
      tick;
      b.hb = 1'b0; b.vid_req = 1'b1; b.vid_addr = 14'(14'h100 + j);
      b.cpu_req = (j == 0); b.cpu_we = 1'b1;
      b.cpu_addr = 14'h0040; b.cpu_wdata = 8'h3C;
      if (j == 0) cpu_q.push_back(exp_crd);
      gh[j] = (j != 3);
      if (gh[j]) vid_q.push_back(ram[14'(14'h100 + j)]);
      #1;
      vec++;
      if (b.vid_gnt !== gh[j]) begin
        errs++; $display("FAIL slot_gnt[%0d]: got %b want %b", j, b.vid_gnt, gh[j]);
      end
      if (b.mem_we) wes++;
      if (j >= 2) begin
        vec++;
        if (b.vid_valid !== gh[j-2]) begin
          errs++;
          $display("FAIL slot_valid[%0d]: got %b want %b", j, b.vid_valid, gh[j-2]);
        end
      end
      if (j == 4) begin
        vec++;
        if (b.mem_we !== 1'b1 || b.mem_addr !== 14'h0040 || b.mem_wdata !== 8'h3C) begin
          errs++;
          $display("FAIL slot_wr: we=%b addr=%h d=%h want 1/0040/3c",
                   b.mem_we, b.mem_addr, b.mem_wdata);
        end
      end
    end
    tick; b.vid_req = 1'b0; b.hb = 1'b1; b.cpu_req = 1'b0;
    tick; tick; tick;
    vec++;
    if (wes != 1) begin
      errs++; $display("FAIL slot_we_count: got %0d want 1", wes);
    end
    vec++;
    if (ram[14'h0040] !== 8'h3C) begin
      errs++; $display("FAIL slot_ram: got %h want 3c", ram[14'h0040]);
    end
  endtask

  task automatic test_blank_mid_wait();
    logic eg;
    for (int j = 0; j < 8; j++) begin
      tick;
      b.hb = (j >= 2); b.vid_req = 1'b1; b.vid_addr = 14'(14'h180 + j);
      b.cpu_req = (j == 0); b.cpu_we = 1'b0; b.cpu_addr = 14'h0200;
      if (j == 0) begin
        cpu_q.push_back(ram[14'h0200]);
        exp_crd = ram[14'h0200];
      end
      eg = (j != 2);
      if (eg) vid_q.push_back(ram[14'(14'h180 + j)]);
      #1;
      vec++;
      if (b.vid_gnt !== eg) begin
        errs++; $display("FAIL midblank_gnt[%0d]: got %b want %b", j, b.vid_gnt, eg);
      end
      if (j == 3 || j == 5) begin
        vec++;
        if (u_dut.slot_cnt !== 2'd0) begin
          errs++; $display("FAIL midblank_slot[%0d]: got %0d want 0", j, u_dut.slot_cnt);
        end
      end
      if (j == 4) begin
        vec++;
        if (b.cpu_ack !== 1'b1) begin
          errs++; $display("FAIL midblank_ack: got %b want 1", b.cpu_ack);
        end
      end
    end
    tick; b.vid_req = 1'b0; b.cpu_req = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_busy_drop();
    int acks, wes;
    acks = 0; wes = 0;
    b.hb = 1'b1; b.vid_req = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick;
      b.cpu_req = (j <= 2); b.cpu_we = 1'b1;
      b.cpu_addr = (j == 0) ? 14'h0300 : 14'h0301;
      b.cpu_wdata = (j == 0) ? 8'h11 : 8'h22;
      if (j == 0) cpu_q.push_back(exp_crd);
      #1;
      if (b.cpu_ack) acks++;
      if (b.mem_we) wes++;
      if (j == 3 || j == 4) begin
        vec++;
        if (b.cpu_busy !== (j == 3)) begin
          errs++; $display("FAIL drop_busy[%0d]: got %b want %b", j, b.cpu_busy, j == 3);
        end
      end
      if (j == 4) b.cpu_req = 1'b0;
    end
    vec++;
    if (acks != 1 || wes != 1) begin
      errs++; $display("FAIL drop_count: acks=%0d we=%0d want 1/1", acks, wes);
    end
    vec++;
    if (ram[14'h0300] !== 8'h11 || ram[14'h0301] !== ramf(14'h0301)) begin
      errs++;
      $display("FAIL drop_ram: %h %h want 11 %h",
               ram[14'h0300], ram[14'h0301], ramf(14'h0301));
    end
  endtask

  task automatic test_starve();
    for (int j = 0; j < K + 5; j++) begin
      tick;
      b16.hb = 1'b0; b16.vid_req = 1'b1; b16.vid_addr = 14'(j);
      b16.cpu_req = (j == 0); b16.cpu_we = 1'b0; b16.cpu_addr = 14'h0400;
      #1;
      vec++;
      if (b16.vid_gnt !== (j != K)) begin
        errs++; $display("FAIL starve_gnt[%0d]: got %b want %b", j, b16.vid_gnt, j != K);
      end
      vec++;
      if (b16.cpu_ack !== (j == K + 2)) begin
        errs++; $display("FAIL starve_ack[%0d]: got %b want %b", j, b16.cpu_ack, j == K + 2);
      end
      if (j == K + 2) begin
        vec++;
        if (b16.cpu_rdata !== ramf(14'h0400)) begin
          errs++; $display("FAIL starve_data: got %h want %h", b16.cpu_rdata, ramf(14'h0400));
        end
      end
      if (j == K + 1) begin
        vec++;
        if (b16.starve_flag !== GUARD) begin
          errs++; $display("FAIL starve_flag: got %b want %b", b16.starve_flag, GUARD);
        end
      end
    end
    tick; b16.cpu_req = 1'b0; b16.vid_req = 1'b0; b16.hb = 1'b1;
    tick; tick; tick; #1;
    vec++;
    if (b16.starve_flag !== GUARD) begin
      errs++; $display("FAIL starve_sticky: got %b want %b", b16.starve_flag, GUARD);
    end
  endtask

  task automatic test_reset_midflight();
    b.hb = 1'b1; b.vid_req = 1'b0;
    tick; b.cpu_req = 1'b1; b.cpu_we = 1'b0; b.cpu_addr = 14'h0500;
    tick; b.cpu_req = 1'b0;
    tick;
    vec++;
    if (b.mem_addr !== 14'h0500) begin
      errs++; $display("FAIL rst_pre_addr: got %h want 0500", b.mem_addr);
    end
    reset = 1'b1; b.vid_req = 1'b1; #1;
    vec++;
    if (outs_b() !== '0) begin
      errs++; $display("FAIL rst_mid_outs: got %h want 0", outs_b());
    end
    vec++;
    if (outs_b16() !== '0) begin
      errs++; $display("FAIL rst_mid_outs16: got %h want 0", outs_b16());
    end
    tick; #1;
    vec++;
    if (outs_b() !== '0) begin
      errs++; $display("FAIL rst_hold_outs: got %h want 0", outs_b());
    end
    tick; reset = 1'b0; b.vid_req = 1'b0; exp_crd = 8'h00;
    tick; b.cpu_req = 1'b1; b.cpu_we = 1'b0; b.cpu_addr = 14'h0501;
    cpu_q.push_back(ram[14'h0501]); exp_crd = ram[14'h0501];
    tick; b.cpu_req = 1'b0;
    tick; tick; #1;
    vec++;
    if (b.cpu_ack !== 1'b1 || b.cpu_rdata !== ramf(14'h0501)) begin
      errs++;
      $display("FAIL rst_after: ack=%b d=%h want 1/%h",
               b.cpu_ack, b.cpu_rdata, ramf(14'h0501));
    end
    tick; tick;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: timeout at %0t want finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_blank_rw();
    test_active_slot();
    test_blank_mid_wait();
    test_busy_drop();
    test_starve();
    test_reset_midflight();
    vec++;
    if (cpu_q.size() != 0 || vid_q.size() != 0) begin
      errs++;
      $display("FAIL sb_drain: cpu=%0d vid=%0d left want 0/0",
               cpu_q.size(), vid_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
